bus_err_injector_bare: RTL and testbench
========================================

// Module: bus_err_injector_bare
// PURPOSE
// Error-response generator for the bus error unit's monitored interface: sits on the response path and rewrites
// the response error code of transactions whose request address hits a programmed window. Per-channel tag FIFOs
// pair each response burst with its request, as the error unit does. Drives error-handling and error-log tests.
// PARAMETERS
// AddrWidth      48  request address width
// ErrBits        3   response error code width
// NumOutstanding 4   tag FIFO depth per channel (max outstanding bursts)
// NumChannels    1   number of one-hot channels
// PORTS
// clk_i            in   1            clock
// rst_i            in   1            reset; one clock; synchronous, active-high
// req_hs_valid_i   in   NumChannels  request handshake, one-hot0
// req_addr_i       in   AddrWidth    request address
// rsp_hs_valid_i   in   NumChannels  response beat handshake, one-hot0
// rsp_burst_last_i in   NumChannels  last beat of response burst
// rsp_err_i        in   ErrBits      upstream response error code
// rsp_err_o        out  ErrBits      response error code after injection
// cfg_arm_i        in   1            pulse: latch cfg_*, start injecting
// cfg_disarm_i     in   1            pulse: stop tagging new requests
// cfg_base_i       in   AddrWidth    window base
// cfg_mask_i       in   AddrWidth    window compare mask (1 = bit compared)
// cfg_code_i       in   ErrBits      injected error code
// cfg_count_i      in   8            requests to tag; 0 = unlimited
// inj_active_o     out  1            state != IDLE
// inj_done_o       out  1            1-cycle pulse on DRAIN->IDLE
// inj_bursts_o     out  16           injected bursts, saturating
// inj_overflow_o   out  1            sticky: a tag FIFO overflowed
// BEHAVIOUR
// - Reset: state IDLE, FIFOs empty, remaining=0, latched cfg=0, dead=0; outputs 0 except rsp_err_o=rsp_err_i.
// - States: IDLE, ARMED, DRAIN.
//   IDLE->ARMED: cfg_arm_i && cfg_code_i!=0; latch base/mask/code/count; remaining=count. Code 0: arm ignored.
//   ARMED->DRAIN: cfg_disarm_i, or a tagged request while remaining==1.
//   DRAIN->IDLE: hit_pending==0 (no hit tags in any FIFO); inj_done_o pulses that cycle.
//   cfg_arm_i outside IDLE is ignored; cfg_disarm_i outside ARMED is ignored.
// - Tagging: every req_hs_valid_i[i] pushes 1-bit hit into FIFO i, unless channel i is dead or its FIFO is full.
//   hit = ARMED && ((req_addr_i ^ base) & mask)==0. Hit decrements remaining when count!=0.
//   A request in the arm cycle sees IDLE: hit=0.
// - Injection, 0-cycle combinational: rsp_hs_valid_i[i] && FIFO i non-empty && head hit && !dead[i]
//   -> rsp_err_o=latched code, on every beat of the burst; otherwise rsp_err_o=rsp_err_i.
//   Latched code holds until next arm, so DRAIN-phase bursts still inject.
// - Pop FIFO i on rsp_hs_valid_i[i] && rsp_burst_last_i[i] && non-empty. Pop on empty is ignored, passthrough.
//   On a hit pop, inj_bursts_o += 1, saturating at 0xFFFF.
// - Push and pop on the same channel in the same cycle: both occur; occupancy unchanged; full does not block that push.
// - Overflow: req_hs_valid_i[i] while FIFO i full and not popping -> dead[i]=1, inj_overflow_o=1 (sticky to reset).
//   A dead channel stops push/pop and passes responses through. Its hit tags are dropped from hit_pending.
// - hit_pending: count of hit tags held; +1 on hit push, -1 on hit pop; width clog2(NumChannels*NumOutstanding+1).
// - Reset mid-operation: state, FIFOs and counters cleared next edge; in-flight bursts pass through.
// - Non-one-hot req/rsp valid: simulation assertion fatal.
// STRUCTURE
// - Package bus_err_inj_pkg: typedef enum logic [1:0] {IDLE, ARMED, DRAIN} inj_state_e; localparam CountWidth=8.
// - Sub-module bus_err_inj_tag_fifo: 1-bit, NumOutstanding-deep, sync active-high reset FIFO
//   with ptrs + usage counter; ports push/pop/data/full/empty; generated once per channel.
// - Top: FSM, window compare, remaining counter, hit_pending, dead flags, output mux.
// TESTING
// - Arm base=0x1000 mask=~0xFFF code=3 count=0; req 0x1004, 4-beat rsp err=0 -> rsp_err_o=3 all beats, inj_bursts_o=1.
// - Same cfg; req 0x2000 -> rsp_err_o follows rsp_err_i (0 and 5 passthrough); inj_bursts_o unchanged.
// - count=2; 3 hitting reqs -> ARMED->DRAIN after 2nd; 3rd burst passthrough; inj_done_o pulse after 2nd burst last.
// - NumOutstanding=4; 5 reqs, no rsp -> inj_overflow_o=1, dead[0]=1; subsequent responses passthrough.
// - Same-cycle push+pop at full FIFO -> no overflow, order preserved; rst_i mid-burst -> IDLE, outputs reset values.
// - Arm with code=0 or while ARMED -> no state change; req in arm cycle untagged.

Source files
------------

// File: rtl/bus_err_inj_pkg.sv
// Shared types and widths for the bus error-response injector.
package bus_err_inj_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DRAIN = 2'd2
   } inj_state_e;

   localparam int unsigned CountWidth = 8;
   localparam int unsigned BurstWidth = 16;

endpackage

// File: rtl/bus_err_inj_tag_fifo.sv
// Per-channel 1-bit tag FIFO pairing each response burst with the hit flag of its request.
module bus_err_inj_tag_fifo #(
   parameter int unsigned Depth = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  logic data_i,
   input  logic pop_i,
   output logic data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntWidth = $clog2(Depth + 1);

   logic [Depth-1:0]    mem_q, mem_d;
   logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;

   function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q + CntWidth'(push_i) - CntWidth'(pop_i);
      if (push_i) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (pop_i) begin
         rd_ptr_d = ptr_next(rd_ptr_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (cnt_q == CntWidth'(Depth));
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/bus_err_injector_bare.sv
// Rewrites the response error code of bursts whose request address hit a programmed window.
module bus_err_injector_bare
   import bus_err_inj_pkg::*;
#(
   parameter int unsigned AddrWidth      = 48,
   parameter int unsigned ErrBits        = 3,
   parameter int unsigned NumOutstanding = 4,
   parameter int unsigned NumChannels    = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NumChannels-1:0] req_hs_valid_i,
   input  logic [AddrWidth-1:0]   req_addr_i,
   input  logic [NumChannels-1:0] rsp_hs_valid_i,
   input  logic [NumChannels-1:0] rsp_burst_last_i,
   input  logic [ErrBits-1:0]     rsp_err_i,
   output logic [ErrBits-1:0]     rsp_err_o,
   input  logic                   cfg_arm_i,
   input  logic                   cfg_disarm_i,
   input  logic [AddrWidth-1:0]   cfg_base_i,
   input  logic [AddrWidth-1:0]   cfg_mask_i,
   input  logic [ErrBits-1:0]     cfg_code_i,
   input  logic [CountWidth-1:0]  cfg_count_i,
   output logic                   inj_active_o,
   output logic                   inj_done_o,
   output logic [BurstWidth-1:0]  inj_bursts_o,
   output logic                   inj_overflow_o
);

   localparam int unsigned OccWidth  = $clog2(NumOutstanding + 1);
   localparam int unsigned PendWidth = $clog2(NumChannels * NumOutstanding + 1);

   inj_state_e             state_q, state_d;
   logic [AddrWidth-1:0]   base_q, base_d;
   logic [AddrWidth-1:0]   mask_q, mask_d;
   logic [ErrBits-1:0]     code_q, code_d;
   logic [CountWidth-1:0]  count_q, count_d;
   logic [CountWidth-1:0]  remaining_q, remaining_d;
   logic [NumChannels-1:0] dead_q, dead_d;
   logic                   overflow_q, overflow_d;
   logic                   done_q, done_d;
   logic [BurstWidth-1:0]  bursts_q, bursts_d;
   logic [OccWidth-1:0]    hit_cnt_q [NumChannels];
   logic [OccWidth-1:0]    hit_cnt_d [NumChannels];

   logic [NumChannels-1:0] fifo_full, fifo_empty, fifo_head;
   logic [NumChannels-1:0] push_en, pop_en, ovf_ev, inj_sel;
   logic                   hit_c;
   logic                   tag_push;
   logic                   hit_pop;
   logic [PendWidth-1:0]   hit_pending;

   assign hit_c = (state_q == ARMED) && (((req_addr_i ^ base_q) & mask_q) == '0);

   // Per-channel handshake qualification and tag FIFO.
   for (genvar g = 0; g < int'(NumChannels); g++) begin : g_chan
      assign pop_en[g]  = rsp_hs_valid_i[g] && rsp_burst_last_i[g] && !fifo_empty[g] && !dead_q[g];
      assign push_en[g] = req_hs_valid_i[g] && !dead_q[g] && (!fifo_full[g] || pop_en[g]);
      assign ovf_ev[g]  = req_hs_valid_i[g] && !dead_q[g] && fifo_full[g] && !pop_en[g];
      assign inj_sel[g] = rsp_hs_valid_i[g] && !fifo_empty[g] && fifo_head[g] && !dead_q[g];

      bus_err_inj_tag_fifo #(
         .Depth (NumOutstanding)
      ) u_tag_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (push_en[g]),
         .data_i  (hit_c),
         .pop_i   (pop_en[g]),
         .data_o  (fifo_head[g]),
         .full_o  (fifo_full[g]),
         .empty_o (fifo_empty[g])
      );
   end

   assign tag_push = (|push_en) && hit_c;
   assign hit_pop  = |(pop_en & fifo_head);

   // Hit-tag bookkeeping; a dead channel forfeits its outstanding hit tags.
   always_comb begin
      dead_d      = dead_q;
      overflow_d  = overflow_q;
      hit_pending = '0;
      for (int i = 0; i < int'(NumChannels); i++) begin
         hit_pending  = hit_pending + PendWidth'(hit_cnt_q[i]);
         hit_cnt_d[i] = hit_cnt_q[i] + OccWidth'(push_en[i] && hit_c)
                                     - OccWidth'(pop_en[i] && fifo_head[i]);
         if (ovf_ev[i]) begin
            hit_cnt_d[i] = '0;
            dead_d[i]    = 1'b1;
            overflow_d   = 1'b1;
         end
      end
      bursts_d = bursts_q;
      if (hit_pop && (bursts_q != '1)) begin
         bursts_d = bursts_q + BurstWidth'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      mask_d      = mask_q;
      code_d      = code_q;
      count_d     = count_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cfg_arm_i && (cfg_code_i != '0)) begin
               state_d     = ARMED;
               base_d      = cfg_base_i;
               mask_d      = cfg_mask_i;
               code_d      = cfg_code_i;
               count_d     = cfg_count_i;
               remaining_d = cfg_count_i;
            end
         end
         ARMED: begin
            if (tag_push && (count_q != '0)) begin
               remaining_d = remaining_q - CountWidth'(1);
            end
            if (cfg_disarm_i || (tag_push && (remaining_q == CountWidth'(1)))) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (hit_pending == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         base_q      <= '0;
         mask_q      <= '0;
         code_q      <= '0;
         count_q     <= '0;
         remaining_q <= '0;
         dead_q      <= '0;
         overflow_q  <= 1'b0;
         done_q      <= 1'b0;
         bursts_q    <= '0;
         for (int i = 0; i < int'(NumChannels); i++) begin
            hit_cnt_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         mask_q      <= mask_d;
         code_q      <= code_d;
         count_q     <= count_d;
         remaining_q <= remaining_d;
         dead_q      <= dead_d;
         overflow_q  <= overflow_d;
         done_q      <= done_d;
         bursts_q    <= bursts_d;
         for (int i = 0; i < int'(NumChannels); i++) begin
            hit_cnt_q[i] <= hit_cnt_d[i];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert ($onehot0(req_hs_valid_i))
            else $fatal(1, "req_hs_valid_i not one-hot0: %b", req_hs_valid_i);
         assert ($onehot0(rsp_hs_valid_i))
            else $fatal(1, "rsp_hs_valid_i not one-hot0: %b", rsp_hs_valid_i);
      end
   end

   assign rsp_err_o      = (|inj_sel) ? code_q : rsp_err_i;
   assign inj_active_o   = (state_q != IDLE);
   assign inj_done_o     = done_q;
   assign inj_bursts_o   = bursts_q;
   assign inj_overflow_o = overflow_q;

endmodule

// File: tb/tb_bus_err_injector_bare.sv
// Directed and randomized bench for bus_err_injector_bare against a queue-based reference model.
module tb_bus_err_injector_bare;

   localparam int unsigned AW = 48;
   localparam int unsigned EB = 3;
   localparam int unsigned NO = 4;
   localparam int unsigned NC = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, req_v, rsp_v, last, arm, disarm;
   logic [AW-1:0] addr, base, mask;
   logic [EB-1:0] rsp_err, code;
   logic [7:0]    count;
   logic [EB-1:0] rsp_err_o;
   logic          inj_active_o, inj_done_o, inj_overflow_o;
   logic [15:0]   inj_bursts_o;

   bus_err_injector_bare #(
      .AddrWidth      (AW),
      .ErrBits        (EB),
      .NumOutstanding (NO),
      .NumChannels    (NC)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .req_hs_valid_i   (req_v),
      .req_addr_i       (addr),
      .rsp_hs_valid_i   (rsp_v),
      .rsp_burst_last_i (last),
      .rsp_err_i        (rsp_err),
      .rsp_err_o        (rsp_err_o),
      .cfg_arm_i        (arm),
      .cfg_disarm_i     (disarm),
      .cfg_base_i       (base),
      .cfg_mask_i       (mask),
      .cfg_code_i       (code),
      .cfg_count_i      (count),
      .inj_active_o     (inj_active_o),
      .inj_done_o       (inj_done_o),
      .inj_bursts_o     (inj_bursts_o),
      .inj_overflow_o   (inj_overflow_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: 0 = idle, 1 = armed, 2 = drain; one queue of hit flags.
   int            m_st;
   bit            m_q[$];
   bit            m_dead, m_ovf, m_done;
   int            m_bursts, m_count, m_rem;
   logic [AW-1:0] m_base, m_mask;
   logic [EB-1:0] m_code;

   function automatic int pending_hits();
      int n = 0;
      if (m_dead) return 0;
      foreach (m_q[k]) if (m_q[k]) n++;
      return n;
   endfunction

   task automatic model_update();
      bit pop, push, ovf, hit, h;
      int pend;
      if (rst) begin
         m_st = 0; m_q.delete(); m_dead = 0; m_ovf = 0; m_done = 0; m_bursts = 0;
         m_count = 0; m_rem = 0; m_base = '0; m_mask = '0; m_code = '0;
         return;
      end
      pop  = rsp_v && last && (m_q.size() > 0) && !m_dead;
      push = req_v && !m_dead && ((m_q.size() < int'(NO)) || pop);
      ovf  = req_v && !m_dead && (m_q.size() == int'(NO)) && !pop;
      hit  = (m_st == 1) && (((addr ^ m_base) & m_mask) == '0);
      pend = pending_hits();
      m_done = 0;
      if (m_st == 0) begin
         if (arm && code != 0) begin
            m_st = 1; m_base = base; m_mask = mask; m_code = code;
            m_count = int'(count); m_rem = int'(count);
         end
      end else if (m_st == 1) begin
         if (disarm || (push && hit && m_rem == 1)) m_st = 2;
         if (push && hit && m_count != 0) m_rem--;
      end else begin
         if (pend == 0) begin
            m_st = 0; m_done = 1;
         end
      end
      if (pop) begin
         h = m_q.pop_front();
         if (h && m_bursts < 65535) m_bursts++;
      end
      if (push) m_q.push_back(hit);
      if (ovf) begin
         m_dead = 1; m_ovf = 1;
      end
   endtask

   // One clock: check outputs mid-cycle, advance model, then clear pulse inputs.
   task automatic step(input int exp_err = -1);
      logic [EB-1:0] e;
      @(negedge clk);
      e = (rsp_v && m_q.size() > 0 && !m_dead && m_q[0]) ? m_code : rsp_err;
      check_eq("rsp_err_o", 64'(rsp_err_o), 64'(e));
      check_eq("inj_active_o", 64'(inj_active_o), 64'(m_st != 0));
      check_eq("inj_done_o", 64'(inj_done_o), 64'(m_done));
      check_eq("inj_bursts_o", 64'(inj_bursts_o), 64'(m_bursts));
      check_eq("inj_overflow_o", 64'(inj_overflow_o), 64'(m_ovf));
      if (exp_err >= 0) check_eq("directed_err", 64'(rsp_err_o), 64'(exp_err));
      model_update();
      @(posedge clk);
      #1;
      rst = 0; req_v = 0; rsp_v = 0; last = 0; arm = 0; disarm = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      step();
   endtask

   task automatic do_arm(input logic [EB-1:0] c, input logic [7:0] n);
      arm = 1; base = 48'h1000; mask = ~48'hFFF; code = c; count = n;
      step();
   endtask

   task automatic do_req(input logic [AW-1:0] a);
      req_v = 1; addr = a;
      step();
   endtask

   task automatic do_beat(input logic [EB-1:0] err, input bit is_last, input int exp_err);
      rsp_v = 1; last = is_last; rsp_err = err;
      step(exp_err);
   endtask

   int dones;

   initial begin
      rst = 1; req_v = 0; rsp_v = 0; last = 0; arm = 0; disarm = 0;
      addr = '0; base = '0; mask = '0; rsp_err = 3'd5; code = '0; count = '0;
      m_st = 0; m_dead = 0; m_ovf = 0; m_done = 0; m_bursts = 0;
      m_count = 0; m_rem = 0; m_base = '0; m_mask = '0; m_code = '0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      check_eq("reset_active", 64'(inj_active_o), 64'd0);
      check_eq("reset_bursts", 64'(inj_bursts_o), 64'd0);

      // Window hit: all four beats carry the injected code.
      do_arm(3'd3, 8'd0);
      do_req(48'h1004);
      do_beat(3'd0, 0, 3);
      do_beat(3'd0, 0, 3);
      do_beat(3'd0, 0, 3);
      do_beat(3'd0, 1, 3);
      check_eq("s1_bursts", 64'(inj_bursts_o), 64'd1);

      // Window miss passes upstream codes through.
      do_req(48'h2000);
      do_beat(3'd0, 0, 0);
      do_beat(3'd5, 1, 5);
      check_eq("s2_bursts", 64'(inj_bursts_o), 64'd1);

      // Request budget of two: third request untagged, done pulses once.
      do_reset();
      do_arm(3'd3, 8'd2);
      do_req(48'h1010);
      check_eq("s3_active1", 64'(inj_active_o), 64'd1);
      do_req(48'h1020);
      do_req(48'h1030);
      do_beat(3'd6, 1, 3);
      do_beat(3'd6, 1, 3);
      dones = 0;
      do_beat(3'd6, 1, 6);
      dones += int'(inj_done_o);
      repeat (3) begin
         step();
         dones += int'(inj_done_o);
      end
      check_eq("s3_done_pulses", 64'(dones), 64'd1);
      check_eq("s3_active_end", 64'(inj_active_o), 64'd0);

      // Overflow kills the channel; later responses pass through.
      do_reset();
      do_arm(3'd3, 8'd0);
      repeat (5) do_req(48'h1000);
      check_eq("s4_overflow", 64'(inj_overflow_o), 64'd1);
      do_beat(3'd2, 1, 2);
      check_eq("s4_bursts", 64'(inj_bursts_o), 64'd0);
      disarm = 1;
      step();
      repeat (2) step();

      // Full FIFO with simultaneous push and pop keeps order.
      do_reset();
      do_arm(3'd3, 8'd0);
      do_req(48'h1000);
      do_req(48'h5000);
      do_req(48'h1008);
      do_req(48'h1FFF);
      req_v = 1; addr = 48'h7000;
      do_beat(3'd1, 1, 3);
      check_eq("s5_no_overflow", 64'(inj_overflow_o), 64'd0);
      do_beat(3'd1, 1, 1);
      do_beat(3'd1, 1, 3);
      do_beat(3'd1, 1, 3);
      do_beat(3'd1, 1, 1);
      do_beat(3'd1, 1, 1);
      check_eq("s5_bursts", 64'(inj_bursts_o), 64'd3);
      do_req(48'h1000);
      do_beat(3'd1, 0, 3);
      rst = 1; rsp_v = 1; rsp_err = 3'd1;
      step();
      do_beat(3'd1, 1, 1);
      check_eq("s5_rst_active", 64'(inj_active_o), 64'd0);
      check_eq("s5_rst_bursts", 64'(inj_bursts_o), 64'd0);

      // Ignored arms and request in the arm cycle.
      do_reset();
      do_arm(3'd0, 8'd0);
      check_eq("s6_code0_idle", 64'(inj_active_o), 64'd0);
      req_v = 1; addr = 48'h1000;
      do_arm(3'd3, 8'd0);
      check_eq("s6_armed", 64'(inj_active_o), 64'd1);
      do_arm(3'd5, 8'd1);
      do_beat(3'd0, 1, 0);
      do_req(48'h1000);
      do_beat(3'd0, 1, 3);

      // Randomized traffic.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst    = ($urandom_range(0, 299) == 0);
         arm    = ($urandom_range(0, 14) == 0);
         disarm = ($urandom_range(0, 29) == 0);
         code   = EB'($urandom_range(0, 7));
         count  = 8'($urandom_range(0, 3));
         base   = 48'h1000 * 48'($urandom_range(1, 4));
         mask   = ($urandom_range(0, 3) == 0) ? {16'h0, $urandom} : ~48'hFFF;
         req_v  = ($urandom_range(0, 2) == 0);
         addr   = ($urandom_range(0, 1) == 0) ? (48'h1000 * 48'($urandom_range(1, 4)) + 48'($urandom_range(0, 15)))
                                              : {16'($urandom), $urandom};
         rsp_v  = ($urandom_range(0, 2) == 0);
         last   = ($urandom_range(0, 1) == 0);
         rsp_err = EB'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
